// File: rtl/vga_fb_scheduler_if.sv
// ============================================================================
//  Module      : vga_fb_scheduler_if
//  Description : Scan position, writer handshake, RAM and colour-path signals
//                shared between the framebuffer scheduler and its neighbours.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_fb_scheduler_if #(
    parameter int DATA_W     = 6,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [9:0]        x_addr;
    logic [9:0]        y_addr;
    logic              wr_valid;
    logic              wr_ready;
    logic [7:0]        wr_x;
    logic [7:0]        wr_y;
    logic [DATA_W-1:0] wr_data;
    logic [15:0]       fb_addr;
    logic              fb_we;
    logic [DATA_W-1:0] fb_wdata;
    logic [DATA_W-1:0] fb_rdata;
    logic [DATA_W-1:0] pix_data;
    logic              pix_in_window;
    logic [LVL_W-1:0]  fifo_level;
    logic              err_oob;

    modport master (
        output x_addr, y_addr, wr_valid, wr_x, wr_y, wr_data, fb_rdata,
        input  wr_ready, fb_addr, fb_we, fb_wdata, pix_data, pix_in_window,
               fifo_level, err_oob
    );

    modport slave (
        input  x_addr, y_addr, wr_valid, wr_x, wr_y, wr_data, fb_rdata,
        output wr_ready, fb_addr, fb_we, fb_wdata, pix_data, pix_in_window,
               fifo_level, err_oob
    );
endinterface

`default_nettype wire

// File: rtl/vga_fb_scheduler.sv
// ============================================================================
//  Module      : vga_fb_scheduler
//  Description : Alternates one single-port framebuffer RAM between VGA scanout
//                reads and FIFO-buffered writer pixels on a 2-cycle schedule.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_fb_scheduler #(
    parameter int DATA_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int X_OFF      = 64,
    parameter int BORDER     = 0
) (
    input  wire logic          clock,
    input  wire logic          reset,
    vga_fb_scheduler_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [10:0]       c_X_LO   = 11'(X_OFF);
    localparam logic [10:0]       c_X_HI   = 11'(X_OFF + 512);
    localparam logic [9:0]        c_X_OFF  = 10'(X_OFF);
    localparam logic [DATA_W-1:0] c_BORDER = DATA_W'(BORDER);
    localparam logic [LVL_W-1:0]  c_FULL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        PH_READ  = 1'b0,
        PH_WRITE = 1'b1
    } phase_t;

    phase_t              r_phase;
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_win_pipe;
    logic [DATA_W-1:0]   r_pix;
    logic                r_pix_win;
    logic                r_err_oob;

    logic [7:0]          r_mem_x [FIFO_DEPTH];
    logic [7:0]          r_mem_y [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_mem_d [FIFO_DEPTH];

    logic                w_in_win;
    logic [9:0]          w_x_rel;
    logic [15:0]         w_scan_addr;
    logic                w_empty;
    logic                w_ready;
    logic                w_beat;
    logic                w_push;
    logic                w_oob;
    logic                w_pop;
    logic                w_fb_we;
    logic [15:0]         w_fb_addr;
    logic [DATA_W-1:0]   w_fb_wdata;
    logic                w_unused;

    // Window test done in 11 bits so X_OFF+512 cannot wrap.
    assign w_in_win    = ({1'b0, bus.x_addr} >= c_X_LO) &&
                         ({1'b0, bus.x_addr} <  c_X_HI) &&
                         (bus.y_addr < 10'd480);
    assign w_x_rel     = bus.x_addr - c_X_OFF;
    assign w_scan_addr = {bus.y_addr[8:1], w_x_rel[8:1]};
    assign w_unused    = &{1'b0, w_x_rel[9], w_x_rel[0], bus.y_addr[9], bus.y_addr[0]};

    assign w_empty = (r_level == '0);
    assign w_ready = (r_level != c_FULL);
    assign w_beat  = bus.wr_valid && w_ready;
    assign w_push  = w_beat && (bus.wr_y <  8'd240);
    assign w_oob   = w_beat && (bus.wr_y >= 8'd240);
    assign w_pop   = (r_phase == PH_WRITE) && !w_empty;

    always_comb begin
        w_fb_we    = 1'b0;
        w_fb_addr  = 16'd0;
        w_fb_wdata = '0;
        if (!reset) begin
            if (r_phase == PH_READ) begin
                if (w_in_win) begin
                    w_fb_addr = w_scan_addr;
                end
            end else if (!w_empty) begin
                w_fb_we    = 1'b1;
                w_fb_addr  = {r_mem_y[r_rptr], r_mem_x[r_rptr]};
                w_fb_wdata = r_mem_d[r_rptr];
            end
        end
    end

    // FIFO storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem_x[r_wptr] <= bus.wr_x;
            r_mem_y[r_wptr] <= bus.wr_y;
            r_mem_d[r_wptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase    <= PH_READ;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_win_pipe <= 1'b0;
            r_pix      <= c_BORDER;
            r_pix_win  <= 1'b0;
            r_err_oob  <= 1'b0;
        end else begin
            r_phase <= (r_phase == PH_READ) ? PH_WRITE : PH_READ;

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            // RAM data for the READ-slot address arrives during the WRITE slot.
            if (r_phase == PH_READ) begin
                r_win_pipe <= w_in_win;
            end else begin
                r_pix     <= r_win_pipe ? bus.fb_rdata : c_BORDER;
                r_pix_win <= r_win_pipe;
            end

            if (w_oob) begin
                r_err_oob <= 1'b1;
            end
        end
    end

    assign bus.wr_ready      = w_ready;
    assign bus.fb_we         = w_fb_we;
    assign bus.fb_addr       = w_fb_addr;
    assign bus.fb_wdata      = w_fb_wdata;
    assign bus.pix_data      = r_pix;
    assign bus.pix_in_window = r_pix_win;
    assign bus.fifo_level    = r_level;
    assign bus.err_oob       = r_err_oob;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_scheduler.sv
// ============================================================================
//  Module      : tb_vga_fb_scheduler
//  Description : Self-checking bench for vga_fb_scheduler with a RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_fb_scheduler;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] addr;
        logic        win;
        logic [5:0]  pix;
    } rvec_t;

    typedef struct {
        logic [5:0] pix;
        logic       win;
    } pexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_fb_scheduler_if #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

    vga_fb_scheduler #(
        .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .X_OFF(64), .BORDER(0)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [5:0] ram [65536];

    always @(posedge clk) begin
        if (bus.fb_we === 1'b1) ram[bus.fb_addr] <= bus.fb_wdata;
        bus.fb_rdata <= ram[bus.fb_addr];
    end

    int          total = 0;
    int          bad   = 0;
    int          wr_cnt = 0;
    int          cyc   = 0;
    int          lvl_m = 0;
    bit          err_m = 1'b0;
    bit          tb_phase = 1'b0;
    bit          chk_en = 1'b0;
    bit          push_m;
    bit          pop_m;
    bit          exp_we;
    logic [21:0] wq [$];
    logic [21:0] we_e;
    pexp_t       pq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input bit p);
        for (int k = 0; k < 4 && tb_phase != p; k++) step();
    endtask

    task automatic send_beat(input logic [7:0] x, input logic [7:0] y, input logic [5:0] d);
        bit acc;
        acc = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_x     = x;
        bus.wr_y     = y;
        bus.wr_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = bus.wr_ready;
            step();
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL beat_timeout got=no_accept want=accept x=%0h y=%0h", x, y);
        end
    endtask

    // Behavioural model of phase, FIFO occupancy and expected RAM writes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            tb_phase <= 1'b0;
            lvl_m    <= 0;
            err_m    <= 1'b0;
            wq.delete();
        end else begin
            push_m = bus.wr_valid && (lvl_m != DEPTH) && (bus.wr_y < 8'd240);
            pop_m  = tb_phase && (lvl_m != 0);
            if (push_m) wq.push_back({bus.wr_y, bus.wr_x, bus.wr_data});
            lvl_m <= lvl_m + int'(push_m) - int'(pop_m);
            if (bus.wr_valid && (lvl_m != DEPTH) && (bus.wr_y >= 8'd240)) err_m <= 1'b1;
            tb_phase <= ~tb_phase;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_we = !rst && tb_phase && (lvl_m != 0);
            chk("fb_we", bus.fb_we, exp_we);
            chk("fifo_level", bus.fifo_level, lvl_m);
            chk("wr_ready", bus.wr_ready, lvl_m != DEPTH);
            chk("err_oob", bus.err_oob, err_m);
            if (bus.fb_we === 1'b1) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write got=addr_%0h want=none", bus.fb_addr);
                end else begin
                    we_e = wq.pop_front();
                    chk("wr_addr", bus.fb_addr, we_e[21:6]);
                    chk("wr_data", bus.fb_wdata, we_e[5:0]);
                    wr_cnt++;
                end
            end else if (tb_phase) begin
                chk("idle_addr", bus.fb_addr, 16'd0);
                chk("idle_wdata", bus.fb_wdata, 6'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rvec_t vt [7];
        pexp_t pe;
        int    base;
        int    start;

        vt[0] = '{x: 10'd66,  y: 10'd2,   addr: 16'h0101, win: 1'b1, pix: 6'h2A};
        vt[1] = '{x: 10'd63,  y: 10'd2,   addr: 16'h0000, win: 1'b0, pix: 6'h00};
        vt[2] = '{x: 10'd576, y: 10'd2,   addr: 16'h0000, win: 1'b0, pix: 6'h00};
        vt[3] = '{x: 10'd66,  y: 10'd480, addr: 16'h0000, win: 1'b0, pix: 6'h00};
        vt[4] = '{x: 10'd64,  y: 10'd0,   addr: 16'h0000, win: 1'b1, pix: 6'h15};
        vt[5] = '{x: 10'd575, y: 10'd479, addr: 16'hEFFF, win: 1'b1, pix: 6'h3F};
        vt[6] = '{x: 10'd100, y: 10'd37,  addr: 16'h1212, win: 1'b1, pix: 6'h07};

        for (int a = 0; a < 65536; a++) ram[a] = 6'd0;
        ram[16'h0101] = 6'h2A;
        ram[16'h0000] = 6'h15;
        ram[16'hEFFF] = 6'h3F;
        ram[16'h1212] = 6'h07;

        bus.x_addr   = 10'd0;
        bus.y_addr   = 10'd0;
        bus.wr_valid = 1'b0;
        bus.wr_x     = 8'd0;
        bus.wr_y     = 8'd0;
        bus.wr_data  = 6'd0;

        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_pix", bus.pix_data, 6'd0);
        chk("rst_win", bus.pix_in_window, 1'b0);
        chk("rst_level", bus.fifo_level, 3'd0);
        chk("rst_ready", bus.wr_ready, 1'b1);
        chk("rst_we0", bus.fb_we, 1'b0);
        step();
        chk("rst_we1", bus.fb_we, 1'b0);

        // Scanout vectors: address checked in the READ slot, pixel two cycles later.
        for (int i = 0; i < 7; i++) begin
            wait_phase(1'b0);
            bus.x_addr = vt[i].x;
            bus.y_addr = vt[i].y;
            #1;
            chk("scan_addr", bus.fb_addr, vt[i].addr);
            pq.push_back('{pix: vt[i].pix, win: vt[i].win});
            step();
            step();
            pe = pq.pop_front();
            chk("pix_n2", bus.pix_data, pe.pix);
            chk("win_n2", bus.pix_in_window, pe.win);
            step();
            chk("pix_n3", bus.pix_data, pe.pix);
            chk("win_n3", bus.pix_in_window, pe.win);
        end
        bus.x_addr = 10'd0;
        bus.y_addr = 10'd0;

        // Six-pixel burst with wr_valid held.
        wait_phase(1'b1);
        base  = wr_cnt;
        start = cyc;
        for (int i = 0; i < 6; i++) send_beat(8'(i), 8'd7, 6'(i + 1));
        bus.wr_valid = 1'b0;
        for (int k = 0; k < 20 && (cyc - start) < 14; k++) step();
        chk("burst_writes", wr_cnt - base, 6);
        for (int i = 0; i < 6; i++) chk("burst_ram", ram[16'h0700 + i], 6'(i + 1));

        // Out-of-range row, then a normal write.
        send_beat(8'd3, 8'd240, 6'd9);
        send_beat(8'd8, 8'd7, 6'h11);
        bus.wr_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("oob_sticky", bus.err_oob, 1'b1);
        chk("after_oob_ram", ram[16'h0708], 6'h11);
        chk("oob_not_written", ram[16'hF003], 6'd0);

        // Reset with three entries still queued.
        wait_phase(1'b1);
        for (int i = 0; i < 4; i++) send_beat(8'(20 + i), 8'd9, 6'(48 + i));
        bus.wr_valid = 1'b0;
        chk("pre_rst_level", bus.fifo_level, 3'd3);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("post_rst_level", bus.fifo_level, 3'd0);
        chk("post_rst_err", bus.err_oob, 1'b0);
        chk("first_kept", ram[16'h0914], 6'd48);
        for (int i = 1; i < 4; i++) chk("discarded", ram[16'h0914 + i], 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_fb_scheduler.md
Name: vga_fb_scheduler

Overview:
- Time-division scheduler sharing one single-port framebuffer RAM between VGA scanout reads and pixel writes from the PPU side.
- Converts the VGA controller's 640x480 x/y scan position into a framebuffer address for a 2x-scaled, horizontally centred 256x240 image.
- Buffers writer traffic in a small FIFO and returns the scanout pixel, or the border colour, to the colour path feeding the VGA block.

Parameters:
- DATA_W, 6: pixel width (palette index).
- FIFO_DEPTH, 4: write FIFO entries; must be a power of 2, at least 2.
- X_OFF, 64: first active VGA column of the scaled image.
- BORDER, 0: pixel value output outside the image window.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- x_addr  in  10  current VGA column from the VGA controller
- y_addr  in  10  current VGA row from the VGA controller
- wr_valid  in  1  writer presents a pixel
- wr_ready  out  1  scheduler can accept a pixel
- wr_x  in  8  writer column, 0..255
- wr_y  in  8  writer row, 0..239 valid
- wr_data  in  DATA_W  writer pixel value
- fb_addr  out  16  RAM address
- fb_we  out  1  RAM write enable
- fb_wdata  out  DATA_W  RAM write data
- fb_rdata  in  DATA_W  RAM read data, 1-cycle latency after address
- pix_data  out  DATA_W  scanout pixel to the colour path
- pix_in_window  out  1  pix_data came from RAM, not border
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- err_oob  out  1  sticky: writer sent wr_y >= 240

Behaviour:
- Reset (synchronous, active-high, overrides all): phase=0, FIFO emptied with contents discarded, pix_data=BORDER, pix_in_window=0, err_oob=0. fb_we=0 during reset and in the first cycle after it.
- Phase register toggles every cycle. Phase 0 is the READ slot; phase 1 is the WRITE slot (matches the 25 MHz pixel rate).
- Window: in_win = (x_addr >= X_OFF) && (x_addr < X_OFF+512) && (y_addr < 480).
- Scan address: {y_addr[8:1], (x_addr-X_OFF)[8:1]}, i.e. (y/2)*256 + (x-X_OFF)/2. Use 10-bit subtraction; only valid when in_win.
- READ slot: fb_we=0. fb_addr = scan address if in_win, else 0. in_win is registered into a 1-stage pipe.
- WRITE slot, FIFO non-empty: fb_we=1, fb_addr = head {y,x}, fb_wdata = head data, head popped at the clock edge.
- WRITE slot, FIFO empty: fb_we=0, fb_addr=0, fb_wdata=0.
- fb_addr, fb_we and fb_wdata are combinational from the phase, FIFO head and x/y.
- Pixel return: at the end of the WRITE-slot cycle, pix_data <= piped in_win ? fb_rdata : BORDER, and pix_in_window <= piped in_win.
  - Latency: x/y sampled in cycle N (phase 0); pix_data valid from cycle N+2 and held for 2 cycles.
- FIFO handshake:
  - wr_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
  - Push occurs when wr_valid && wr_ready && wr_y < 240.
  - wr_y >= 240 with wr_valid && wr_ready: beat consumed, nothing enqueued, err_oob set until reset.
  - Push and pop in the same cycle: level unchanged; a full FIFO stays full and wr_ready stays 0 that cycle.
  - Push into an empty FIFO during a WRITE slot is not written that slot; it waits for the next WRITE slot (no bypass).
  - FIFO order is strict; pointers wrap modulo FIFO_DEPTH.
- Hazard: a READ and a WRITE to the same address in adjacent slots; the read returns pre-write data. No forwarding.
- Worst-case write throughput: 1 pixel per 2 cycles. Scanout never stalls.

Test Plan:
- Reset for 3 cycles, then idle → pix_data=0, pix_in_window=0, fifo_level=0, wr_ready=1; fb_we=0 for the first 2 cycles.
- Preload RAM addr 0x0101 with 0x2A; hold x_addr=66, y_addr=2 from a phase-0 cycle N → fb_addr=0x0101 in cycle N; pix_data=0x2A, pix_in_window=1 at cycles N+2 and N+3.
- x_addr=63 or 576, or y_addr=480 → fb_addr=0 in READ slot; pix_data=BORDER, pix_in_window=0.
- Burst of 6 writes with wr_valid held high, (x,y)=(0..5,7), data 1..6 → wr_ready drops once level reaches 4; RAM gets addr 0x0700..0x0705 in order, one per WRITE slot; all 6 complete within 14 cycles.
- Write wr_y=240 → wr_ready honoured, fifo_level unchanged, err_oob=1 until reset; the next valid write proceeds normally.
- Assert reset with 3 entries queued → after reset, fifo_level=0, no fb_we pulses for the discarded entries, err_oob=0.
